sdram_frame_sched: RTL and testbench

Burst scheduler that shares the single `sdram_top` request port between the capture-side write FIFO and the display-side read FIFO. Frames are double-buffered in SDRAM (ping-pong on address bit 22), and each transfer is one 512-word line burst. The block sits between the two FIFO level counters and `sdram_top`'s `wr/rd_sdram_req/ack` ports. It replaces ad-hoc per-direction request FSMs with one arbitrated, frame-aware controller.

---
 rtl/sdram_sched_pkg.sv | 25 ++
 rtl/sdram_frame_sched_if.sv | 29 ++
 rtl/sdram_pingpong_ptr.sv | 43 ++++
 rtl/sdram_frame_sched.sv | 121 ++++++++++++
 tb/tb_sdram_frame_sched.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/sdram_sched_pkg.sv
// Shared types and SDRAM address layout for the frame burst scheduler.
// One line burst fills the low address bits; the ping-pong buffer is bit 22.
package sdram_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_GAP   = 2'd2,
    S_WHOLD = 2'd3
  } sched_state_t;

  localparam int BURST_LEN = 512;
  localparam int BUF_BIT   = 22;
  localparam int LINE_LSB  = $clog2(BURST_LEN);
  localparam int LINE_W    = 13;

  function automatic logic [23:0] line_addr(input logic buf_sel, input logic [LINE_W-1:0] line);
    logic [23:0] a;
    a = '0;
    a[BUF_BIT] = buf_sel;
    a[LINE_LSB +: LINE_W] = line;
    return a;
  endfunction

endpackage

// File: rtl/sdram_frame_sched_if.sv
// FIFO levels, vsync pulse and the sdram_top request port seen by the scheduler.
// master = scheduler side, slave = FIFO/SDRAM environment side.
interface sdram_frame_sched_if #(
  parameter int FW = 11
);
  logic [FW-1:0] wr_fifo_used_i;
  logic [FW-1:0] rd_fifo_used_i;
  logic          frame_start_i;
  logic          sdram_ack_i;
  logic          sdram_req_o;
  logic          sdram_we_o;
  logic [23:0]   sdram_add_o;
  logic          frame_valid_o;
  logic          wr_frame_done_o;
  logic          rd_buf_o;
  logic          wr_stall_o;

  modport master (
    input  wr_fifo_used_i, rd_fifo_used_i, frame_start_i, sdram_ack_i,
    output sdram_req_o, sdram_we_o, sdram_add_o,
           frame_valid_o, wr_frame_done_o, rd_buf_o, wr_stall_o
  );

  modport slave (
    output wr_fifo_used_i, rd_fifo_used_i, frame_start_i, sdram_ack_i,
    input  sdram_req_o, sdram_we_o, sdram_add_o,
           frame_valid_o, wr_frame_done_o, rd_buf_o, wr_stall_o
  );
endinterface

// File: rtl/sdram_pingpong_ptr.sv
// Ping-pong buffer ownership: which buffer the writer fills, which one is displayed,
// and the writer hold when it would overwrite the buffer on screen.
module sdram_pingpong_ptr (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wr_last_ack,
  input  logic frame_start,
  output logic wr_buf,
  output logic rd_buf,
  output logic frame_valid,
  output logic wr_stall
);

  logic done_buf;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_buf      <= 1'b0;
      rd_buf      <= 1'b0;
      frame_valid <= 1'b0;
      wr_stall    <= 1'b0;
      done_buf    <= 1'b0;
    end else begin
      if (wr_last_ack) begin
        frame_valid <= 1'b1;
        done_buf    <= wr_buf;
        // a coincident vsync hands the just-finished buffer to display, so no clash
        if (frame_valid && !frame_start && (wr_buf != rd_buf))
          wr_stall <= 1'b1;
        else
          wr_buf <= ~wr_buf;
      end
      if (frame_start) begin
        rd_buf <= wr_last_ack ? wr_buf : done_buf;
        if (wr_stall) begin
          wr_buf   <= ~wr_buf;
          wr_stall <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_frame_sched.sv
// Arbitrated, frame-aware line-burst scheduler sharing one sdram_top request port
// between the capture write FIFO and the display read FIFO.
//
//   state   | meaning
//   S_IDLE  | evaluate eligibility, grant write or read
//   S_REQ   | request held, address/direction frozen until ack
//   S_GAP   | GAP_CYC settle cycles after an ack
//   S_WHOLD | writer blocked on display buffer, reads still granted
module sdram_frame_sched
  import sdram_sched_pkg::*;
#(
  parameter int LINES     = 128,
  parameter int WR_THRESH = 512,
  parameter int RD_THRESH = 512,
  parameter int GAP_CYC   = 2,
  parameter int FW        = 11
) (
  input logic                 clk_i,
  input logic                 rst_i,
  sdram_frame_sched_if.master bus
);

  localparam logic [LINE_W-1:0] LINES_L   = LINE_W'(LINES);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
  localparam logic [FW-1:0]     WR_T      = FW'(WR_THRESH);
  localparam logic [FW-1:0]     RD_T      = FW'(RD_THRESH);
  localparam logic [3:0]        GAP_INIT  = 4'(GAP_CYC - 1);

  sched_state_t      state;
  logic [LINE_W-1:0] wr_line, rd_line;
  logic [3:0]        gap_cnt;
  logic              last_rd, rst_pend;
  logic              req, we, done;
  logic [23:0]       add;
  logic              wr_buf, rd_buf, frame_valid, wr_stall;
  logic              rd_busy, wr_elig, rd_elig, wr_go, rd_go, wr_last_ack;

  assign rd_busy = (state == S_REQ) && !we;
  assign wr_elig = (state == S_IDLE) && (bus.wr_fifo_used_i >= WR_T) && !wr_stall;
  // no read grant on the vsync cycle itself, so it never targets the stale line
  assign rd_elig = frame_valid && (rd_line < LINES_L) && (bus.rd_fifo_used_i <= RD_T)
                   && !rst_pend && !bus.frame_start_i;
  assign wr_go   = wr_elig && (!rd_elig || last_rd);
  assign rd_go   = rd_elig && !wr_go;
  assign wr_last_ack = (state == S_REQ) && bus.sdram_ack_i && we && (wr_line == LAST_LINE);

  sdram_pingpong_ptr u_ptr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_last_ack (wr_last_ack),
    .frame_start (bus.frame_start_i),
    .wr_buf      (wr_buf),
    .rd_buf      (rd_buf),
    .frame_valid (frame_valid),
    .wr_stall    (wr_stall)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      req      <= 1'b0;
      we       <= 1'b0;
      add      <= '0;
      done     <= 1'b0;
      wr_line  <= '0;
      rd_line  <= '0;
      gap_cnt  <= '0;
      last_rd  <= 1'b1;
      rst_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.frame_start_i && !rd_busy) rd_line <= '0;
      if (bus.frame_start_i && rd_busy && !bus.sdram_ack_i) rst_pend <= 1'b1;
      case (state)
        S_IDLE, S_WHOLD: begin
          if (state == S_WHOLD && !wr_stall) begin
            state <= S_IDLE;
          end else if (wr_go || rd_go) begin
            req     <= 1'b1;
            we      <= wr_go;
            add     <= wr_go ? line_addr(wr_buf, wr_line) : line_addr(rd_buf, rd_line);
            last_rd <= !wr_go;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.sdram_ack_i) begin
            req     <= 1'b0;
            gap_cnt <= GAP_INIT;
            state   <= S_GAP;
            if (we) begin
              if (wr_line == LAST_LINE) begin
                wr_line <= '0;
                done    <= 1'b1;
              end else begin
                wr_line <= wr_line + 1'b1;
              end
            end else begin
              rst_pend <= 1'b0;
              rd_line  <= (rst_pend || bus.frame_start_i) ? '0 : rd_line + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd0) state <= wr_stall ? S_WHOLD : S_IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.sdram_req_o     = req;
  assign bus.sdram_we_o      = we;
  assign bus.sdram_add_o     = add;
  assign bus.wr_frame_done_o = done;
  assign bus.frame_valid_o   = frame_valid;
  assign bus.rd_buf_o        = rd_buf;
  assign bus.wr_stall_o      = wr_stall;

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Directed bench for sdram_frame_sched with LINES=4, GAP_CYC=2; expected values hand-computed.
module tb_sdram_frame_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  sdram_frame_sched_if #(.FW(11)) bus ();

  sdram_frame_sched #(
    .LINES(4), .WR_THRESH(512), .RD_THRESH(512), .GAP_CYC(2), .FW(11)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic        tie_we  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [23:0] tie_add [4] = '{24'h000000, 24'h400200, 24'h000200, 24'h400400};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!bus.sdram_req_o && n < 50) begin
      tick();
      n++;
    end
    chk("req_seen", bus.sdram_req_o, 1);
  endtask

  task automatic do_ack();
    bus.sdram_ack_i = 1'b1;
    tick();
    bus.sdram_ack_i = 1'b0;
  endtask

  task automatic burst(input string tag, input logic exp_we, input logic [23:0] exp_add,
                       output int gap);
    wait_req(gap);
    chk({tag, "_we"}, bus.sdram_we_o, exp_we);
    chk({tag, "_add"}, bus.sdram_add_o, exp_add);
    do_ack();
    chk({tag, "_req_drop"}, bus.sdram_req_o, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, bus.sdram_req_o, 0);
    chk({tag, "_we"}, bus.sdram_we_o, 0);
    chk({tag, "_add"}, bus.sdram_add_o, 0);
    chk({tag, "_fv"}, bus.frame_valid_o, 0);
    chk({tag, "_done"}, bus.wr_frame_done_o, 0);
    chk({tag, "_rdbuf"}, bus.rd_buf_o, 0);
    chk({tag, "_stall"}, bus.wr_stall_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int hi;
    bus.wr_fifo_used_i = 11'd0;
    bus.rd_fifo_used_i = 11'd2047;
    bus.frame_start_i  = 1'b0;
    bus.sdram_ack_i    = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // first frame into buffer 0, then the writer flips to buffer 1
    bus.wr_fifo_used_i = 11'd600;
    for (int i = 0; i < 4; i++) burst("wr_f1", 1'b1, 24'(i * 'h200), g);
    chk("frame_done", bus.wr_frame_done_o, 1);
    chk("frame_valid", bus.frame_valid_o, 1);
    chk("stall_first_frame", bus.wr_stall_o, 0);
    tick();
    chk("frame_done_1cyc", bus.wr_frame_done_o, 0);
    burst("wr_buf1", 1'b1, 24'h400000, g);

    // tie: last grant was a write, so read goes first and they alternate
    bus.rd_fifo_used_i = 11'd0;
    for (int i = 0; i < 4; i++) begin
      burst("tie", tie_we[i], tie_add[i], g);
      chk("tie_gap", g, 3);
    end

    // second frame completes into buffer 1 while buffer 0 is displayed
    bus.rd_fifo_used_i = 11'd2047;
    burst("wr_f2_last", 1'b1, 24'h400600, g);
    chk("stall_set", bus.wr_stall_o, 1);
    chk("frame_done_f2", bus.wr_frame_done_o, 1);
    bus.rd_fifo_used_i = 11'd0;
    burst("rd_hold_l2", 1'b0, 24'h000400, g);
    burst("rd_hold_l3", 1'b0, 24'h000600, g);
    hi = 0;
    repeat (15) begin
      tick();
      if (bus.sdram_req_o) hi++;
    end
    chk("no_req_exhausted_stalled", hi, 0);
    chk("stall_held", bus.wr_stall_o, 1);

    bus.frame_start_i = 1'b1;
    tick();
    bus.frame_start_i = 1'b0;
    chk("rd_buf_handover", bus.rd_buf_o, 1);
    chk("stall_release", bus.wr_stall_o, 0);
    burst("wr_after_release", 1'b1, 24'h000000, g);
    bus.wr_fifo_used_i = 11'd0;

    burst("rd_new_l0", 1'b0, 24'h400000, g);
    burst("rd_new_l1", 1'b0, 24'h400200, g);

    // vsync while a read burst is outstanding
    wait_req(g);
    chk("rd_l2_add", bus.sdram_add_o, 24'h400400);
    bus.frame_start_i = 1'b1;
    tick();
    bus.frame_start_i = 1'b0;
    chk("req_hold_after_fs", bus.sdram_req_o, 1);
    tick();
    chk("req_hold_after_fs2", bus.sdram_req_o, 1);
    chk("add_frozen", bus.sdram_add_o, 24'h400400);
    do_ack();
    burst("rd_restart", 1'b0, 24'h400000, g);

    // vsync coincident with a read ack
    wait_req(g);
    chk("rd_l1_add", bus.sdram_add_o, 24'h400200);
    bus.frame_start_i = 1'b1;
    do_ack();
    bus.frame_start_i = 1'b0;
    wait_req(g);
    chk("rd_coincident_add", bus.sdram_add_o, 24'h400000);
    chk("rd_coincident_we", bus.sdram_we_o, 0);

    // reset with the request high, then a stray ack
    rst = 1'b1;
    tick();
    chk_reset_outputs("midburst_reset");
    rst = 1'b0;
    bus.sdram_ack_i = 1'b1;
    tick();
    bus.sdram_ack_i = 1'b0;
    hi = 0;
    repeat (5) begin
      tick();
      if (bus.sdram_req_o) hi++;
    end
    chk("no_req_after_stray_ack", hi, 0);
    chk("fv_after_reset", bus.frame_valid_o, 0);
    bus.wr_fifo_used_i = 11'd600;
    burst("wr_post_rst_l0", 1'b1, 24'h000000, g);
    burst("wr_post_rst_l1", 1'b1, 24'h000200, g);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
